// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with double-buffered BCD display word.
// Optional leading-zero blanking is enabled by defining LZB_EN.
module seg_scan_ctrl #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [6:0]       SEG_OFF    = 7'b1111111;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_next;
  logic             w_wrap;
  logic [15:0]      r_shadow;
  logic [15:0]      r_display;
  logic [3:0]       w_nibble;
  logic             w_lzb;
  logic [3:0]       w_an_next;
  logic [6:0]       w_seg_next;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

`ifdef LZB_EN
  // A digit is a leading zero when it and every higher-index digit are zero.
  function automatic logic leading_zero(input logic [15:0] word, input logic [1:0] idx);
    logic z;
    case (idx)
      2'd3:    z = (word[15:12] == 4'd0);
      2'd2:    z = (word[15:8]  == 8'd0);
      2'd1:    z = (word[15:4]  == 12'd0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction
`endif

  // Next-state logic for the slot scanner and the registered output values.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_wrap       = 1'b0;
    w_nibble     = 4'd0;
    w_lzb        = 1'b0;
    w_an_next    = 4'b0000;
    w_seg_next   = SEG_OFF;

    if (!en) begin
      w_state_next = ST_BLANK;
      w_cnt_next   = CNT_ZERO;
      w_idx_next   = 2'd0;
    end else begin
      case (r_state)
        ST_BLANK: begin
          w_cnt_next = r_cnt + CNT_ONE;
          if (r_cnt == BLANK_LAST) begin
            w_state_next = ST_DRIVE;
          end else begin
            w_state_next = ST_BLANK;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == SLOT_LAST) begin
            w_cnt_next   = CNT_ZERO;
            w_idx_next   = r_idx + 2'd1;
            w_state_next = ST_BLANK;
            w_wrap       = (r_idx == 2'd3);
          end else begin
            w_cnt_next   = r_cnt + CNT_ONE;
            w_state_next = ST_DRIVE;
          end
        end
        default: begin
          w_state_next = ST_BLANK;
          w_cnt_next   = CNT_ZERO;
          w_idx_next   = 2'd0;
        end
      endcase
    end

    case (w_idx_next)
      2'd0:    w_nibble = r_display[3:0];
      2'd1:    w_nibble = r_display[7:4];
      2'd2:    w_nibble = r_display[11:8];
      default: w_nibble = r_display[15:12];
    endcase

`ifdef LZB_EN
    w_lzb = leading_zero(r_display, w_idx_next);
`else
    w_lzb = 1'b0;
`endif

    // Display word only changes on a wrap, which always lands in BLANK.
    if (w_state_next == ST_DRIVE) begin
      w_an_next  = 4'b0001 << w_idx_next;
      w_seg_next = w_lzb ? SEG_OFF : glyph(w_nibble);
    end else begin
      w_an_next  = 4'b0000;
      w_seg_next = SEG_OFF;
    end
  end

  // Scanner state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= CNT_ZERO;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  // Shadow/display buffers and registered pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow   <= 16'h0000;
      r_display  <= 16'h0000;
      seg        <= SEG_OFF;
      an         <= 4'b0000;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        r_shadow <= digits_in;
      end else begin
        r_shadow <= r_shadow;
      end
      if (w_wrap) begin
        r_display <= load ? digits_in : r_shadow;
      end else begin
        r_display <= r_display;
      end
      seg        <= w_seg_next;
      an         <= w_an_next;
      frame_done <= w_wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed vector table, hand sequences and
// randomized traffic against a frame-position reference model (honours LZB_EN).
module tb_seg_scan_ctrl;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G9 = 7'b0010000;
`ifdef LZB_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = G0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] digits_in;
  logic        load;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  seg_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .load(load),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: edges since (re)start, shadow and displayed words.
  int          m_k;
  logic [15:0] m_shadow;
  logic [15:0] m_display;
  logic [6:0]  glyph_tbl [16];

  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] din;
    int          n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        fd;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic ref_drive(input int k);
    return (k > 0) && ((k % SLOT) >= BLANK);
  endfunction

  function automatic logic [3:0] ref_an(input int k);
    logic [3:0] a;
    a = 4'b0000;
    if (ref_drive(k)) a[(k % FRAME) / SLOT] = 1'b1;
    return a;
  endfunction

  function automatic logic [6:0] ref_seg(input int k, input logic [15:0] disp);
    int slot;
    logic [15:0] upper;
    slot = (k % FRAME) / SLOT;
    if (!ref_drive(k)) return BL;
    upper = disp >> (4 * slot);
`ifdef LZB_EN
    if (slot >= 1 && upper == 16'h0000) return BL;
`endif
    return glyph_tbl[upper[3:0]];
  endfunction

  function automatic logic ref_fd(input int k);
    return (k > 0) && ((k % FRAME) == 0);
  endfunction

  task automatic model_reset();
    m_k       = 0;
    m_shadow  = 16'h0000;
    m_display = 16'h0000;
  endtask

  task automatic step(input logic e, input logic l, input logic [15:0] d);
    en        = e;
    load      = l;
    digits_in = d;
    @(posedge clk);
    if (e) begin
      m_k++;
      if ((m_k % FRAME) == 0) m_display = l ? d : m_shadow;
    end else begin
      m_k = 0;
    end
    if (l) m_shadow = d;
    #1;
    chk("model_an",  {28'd0, an},  {28'd0, ref_an(m_k)});
    chk("model_seg", {25'd0, seg}, {25'd0, ref_seg(m_k, m_display)});
    chk("model_fd",  {31'd0, frame_done}, {31'd0, ref_fd(m_k)});
  endtask

  task automatic push(input logic e, input logic l, input logic [15:0] d, input int n,
                      input logic [3:0] a, input logic [6:0] s, input logic f);
    vec_t v;
    v.en = e; v.load = l; v.din = d; v.n = n; v.an = a; v.seg = s; v.fd = f;
    tbl.push_back(v);
  endtask

  initial begin
    logic [15:0] w;
    bit found;
    glyph_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                  BL, BL, BL, BL, BL, BL};

    // Directed frames from reset: double buffer, boundary bypass, invalid nibbles.
    push(1'b1,1'b0,16'h0000,1,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b0001,G0,1'b0);
    push(1'b1,1'b0,16'h0000,2,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,2,4'b0010,G0,1'b0);
    push(1'b1,1'b1,16'h1234,1,4'b0010,G0,1'b0);
    push(1'b1,1'b0,16'h0000,3,4'b0010,G0,1'b0);
    push(1'b1,1'b0,16'h0000,2,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b0100,G0,1'b0);
    push(1'b1,1'b0,16'h0000,2,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b1000,G0,1'b0);
    push(1'b1,1'b0,16'h0000,1,4'b0000,BL,1'b1);
    push(1'b1,1'b0,16'h0000,1,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b0001,G4,1'b0);
    push(1'b1,1'b0,16'h0000,2,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b0010,G3,1'b0);
    push(1'b1,1'b0,16'h0000,2,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b0100,G2,1'b0);
    push(1'b1,1'b0,16'h0000,2,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b1000,G1,1'b0);
    push(1'b1,1'b1,16'h0009,1,4'b0000,BL,1'b1);
    push(1'b1,1'b0,16'h0000,1,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b0001,G9,1'b0);
    push(1'b1,1'b1,16'hFA00,1,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,1,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b0010,LZ,1'b0);
    push(1'b1,1'b0,16'h0000,2,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b0100,LZ,1'b0);
    push(1'b1,1'b0,16'h0000,2,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b1000,LZ,1'b0);
    push(1'b1,1'b0,16'h0000,1,4'b0000,BL,1'b1);
    push(1'b1,1'b0,16'h0000,1,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b0001,G0,1'b0);
    push(1'b1,1'b0,16'h0000,2,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b0010,G0,1'b0);
    push(1'b1,1'b0,16'h0000,2,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b0100,BL,1'b0);
    push(1'b1,1'b0,16'h0000,2,4'b0000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,6,4'b1000,BL,1'b0);
    push(1'b1,1'b0,16'h0000,1,4'b0000,BL,1'b1);

    rst = 1'b1; en = 1'b1; load = 1'b0; digits_in = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_an",  {28'd0, an},  32'd0);
    chk("reset_seg", {25'd0, seg}, {25'd0, BL});
    chk("reset_fd",  {31'd0, frame_done}, 32'd0);
    rst = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      for (int c = 0; c < tbl[r].n; c++) begin
        step(tbl[r].en, (c == 0) ? tbl[r].load : 1'b0, tbl[r].din);
        chk($sformatf("vec%0d_an", r),  {28'd0, an},  {28'd0, tbl[r].an});
        chk($sformatf("vec%0d_seg", r), {25'd0, seg}, {25'd0, tbl[r].seg});
        chk($sformatf("vec%0d_fd", r),  {31'd0, frame_done}, {31'd0, tbl[r].fd});
      end
    end

    // Enable drop during slot 2 DRIVE, load while disabled, then restart.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((m_k % FRAME) == 2 * SLOT + 4) begin
        found = 1'b1;
        break;
      end
      step(1'b1, 1'b0, 16'h0000);
    end
    chk("drop_reach_an", {28'd0, an}, 32'd4);
    if (!found) chk("drop_reach_bound", 32'd0, 32'd1);
    step(1'b0, 1'b0, 16'h0000);
    chk("drop_an",  {28'd0, an},  32'd0);
    chk("drop_seg", {25'd0, seg}, {25'd0, BL});
    step(1'b0, 1'b1, 16'h0050);
    for (int i = 1; i < FRAME; i++) begin
      step(1'b1, 1'b0, 16'h0000);
      chk("restart_fd_low", {31'd0, frame_done}, 32'd0);
    end
    step(1'b1, 1'b0, 16'h0000);
    chk("restart_fd_high", {31'd0, frame_done}, 32'd1);
    for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0, 16'h0000);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      for (int n = 0; n < 4; n++)
        w[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0), w);
    end

    // Reset mid-slot: immediate blank, pending shadow discarded.
    step(1'b1, 1'b1, 16'h8888);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_an",  {28'd0, an},  32'd0);
    chk("midrst_seg", {25'd0, seg}, {25'd0, BL});
    chk("midrst_fd",  {31'd0, frame_done}, 32'd0);
    model_reset();
    load = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) step(1'b1, 1'b0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
